// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-bus memory controller:
// access sizes, FSM encoding and a size-to-byte-count helper.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Size code 3 is treated as a word.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_BYTE: n = 3'd1;
            SIZE_HALF: n = 3'd2;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the IF fetch port, MEM data port and byte RAM port.
// slave = controller side, master = surrounding pipeline/RAM side.
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);

    logic              if_en_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [7:0]        if_byte_o;
    logic              stall_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [1:0]        mem_size_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [31:0]       mem_wdata_i;
    logic [31:0]       mem_rdata_o;
    logic              mem_done_o;

    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_wr_o;
    logic [7:0]        ram_dout_o;
    logic [7:0]        ram_din_i;

    modport slave (
        input  if_en_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_size_i,
        input  mem_addr_i, mem_wdata_i,
        input  ram_din_i,
        output if_byte_o, stall_o,
        output mem_rdata_o, mem_done_o,
        output ram_addr_o, ram_wr_o, ram_dout_o
    );

    modport master (
        output if_en_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_size_i,
        output mem_addr_i, mem_wdata_i,
        output ram_din_i,
        input  if_byte_o, stall_o,
        input  mem_rdata_o, mem_done_o,
        input  ram_addr_o, ram_wr_o, ram_dout_o
    );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-bus memory controller: arbitrates one byte-wide RAM port
// between IF fetch and serialised MEM loads/stores (MEM wins).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    mem_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    logic              accept;
    logic [2:0]        rd_idx;
    logic [1:0]        cap_idx;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic              stall;
    logic              unused_if_en;

    assign unused_if_en = bus.if_en_i;

    // Reset is folded in so stall stays low while held in reset.
    assign accept = rst & rdy & (state_q == ST_IDLE)
                  & bus.mem_req_i & ~done_q;

    // The final read step re-presents the last byte address.
    assign rd_idx  = (cnt_q == n_q) ? cnt_q - 3'd1 : cnt_q;
    assign cap_idx = 2'(cnt_q - 3'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            n_q         <= 3'd1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            last_addr_q <= last_addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = done_q;
        if (rdy) begin
            done_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_d  = bus.mem_addr_i;
                        wdata_d = bus.mem_wdata_i;
                        n_d     = size_to_n(bus.mem_size_i);
                        cnt_d   = '0;
                        if (bus.mem_we_i) begin
                            state_d = ST_WRITE;
                        end else begin
                            state_d = ST_READ;
                            rdata_d = '0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == n_q - 3'd1) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                ST_READ: begin
                    if (cnt_q != 3'd0) begin
                        rdata_d[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
                    end
                    if (cnt_q == n_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        ram_addr = bus.if_addr_i;
        ram_wr   = 1'b0;
        ram_dout = '0;
        stall    = accept;
        unique case (state_q)
            ST_WRITE: begin
                ram_addr = addr_q + ADDR_W'(cnt_q);
                ram_wr   = rdy;
                ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                stall    = 1'b1;
            end
            ST_READ: begin
                ram_addr = addr_q + ADDR_W'(rd_idx);
                stall    = 1'b1;
            end
            default: ;
        endcase
        // Frozen cycles keep the RAM looking at the last real address.
        if (!rdy) begin
            ram_addr = last_addr_q;
        end
    end

    assign last_addr_d = rdy ? ram_addr : last_addr_q;

    assign bus.ram_addr_o  = ram_addr;
    assign bus.ram_wr_o    = ram_wr;
    assign bus.ram_dout_o  = ram_dout;
    assign bus.stall_o     = stall;
    assign bus.if_byte_o   = bus.ram_din_i;
    assign bus.mem_rdata_o = rdata_q;
    assign bus.mem_done_o  = done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 4 KiB byte RAM model
// (registered read, address aliased on the low 12 bits).
module tb_mem_ctrl;

    logic clk;
    logic rst;
    logic rdy;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    logic [7:0]  ram [0:4095];
    logic        bk_we;
    logic [11:0] bk_a;
    logic [7:0]  bk_d;

    int n_chk;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_wr_o)
            ram[bus.ram_addr_o[11:0]] <= bus.ram_dout_o;
        else if (bk_we)
            ram[bk_a] <= bk_d;
        bus.ram_din_i <= ram[bus.ram_addr_o[11:0]];
    end

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        bk_we = 1'b1;
        bk_a  = a;
        bk_d  = d;
        @(posedge clk);
        #1;
        bk_we = 1'b0;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rdy = 1'b1;
        bus.if_en_i = 1'b1;
        bus.if_addr_i = 32'h10;
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b1;
        bus.mem_size_i = 2'd2;
        bus.mem_addr_i = 32'h0;
        bus.mem_wdata_i = 32'h0;
        @(negedge clk);
        n_chk++;
        if (bus.mem_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got %b exp 0", bus.mem_done_o);
        end
        n_chk++;
        if (bus.mem_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata got %h exp 0", bus.mem_rdata_o);
        end
        n_chk++;
        if (bus.ram_wr_o !== 1'b0 || bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wr_stall got %b%b exp 00",
                     bus.ram_wr_o, bus.stall_o);
        end
        bus.mem_req_i = 1'b0;
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_if_fetch;
        bus.if_en_i = 1'b1;
        bus.if_addr_i = 32'h10;
        @(negedge clk);
        n_chk++;
        if (bus.ram_addr_o !== 32'h10 || bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL if_addr got %h/%b exp 00000010/0",
                     bus.ram_addr_o, bus.stall_o);
        end
        next_cycle();
        bus.if_addr_i = 32'h11;
        @(negedge clk);
        n_chk++;
        if (bus.if_byte_o !== 8'hAB || bus.stall_o !== 1'b0) begin
            n_fail++;
            $display("FAIL if_byte0 got %h/%b exp ab/0",
                     bus.if_byte_o, bus.stall_o);
        end
        next_cycle();
        @(negedge clk);
        n_chk++;
        if (bus.if_byte_o !== 8'h5C) begin
            n_fail++;
            $display("FAIL if_byte1 got %h exp 5c", bus.if_byte_o);
        end
        next_cycle();
    endtask

    // Also covers contention: IF requests alongside the load.
    task automatic test_word_load;
        logic [31:0] ea;
        bus.if_en_i = 1'b1;
        bus.if_addr_i = 32'h50;
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b0;
        bus.mem_size_i = 2'd2;
        bus.mem_addr_i = 32'h100;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            n_chk++;
            if (bus.stall_o !== (c <= 5)) begin
                n_fail++;
                $display("FAIL wl_stall c=%0d got %b exp %b",
                         c, bus.stall_o, (c <= 5));
            end
            n_chk++;
            if (bus.mem_done_o !== (c == 6) || bus.ram_wr_o !== 1'b0) begin
                n_fail++;
                $display("FAIL wl_done_wr c=%0d got %b%b exp %b0",
                         c, bus.mem_done_o, bus.ram_wr_o, (c == 6));
            end
            if (c >= 1) begin
                ea = (c == 6) ? 32'h50 :
                     (c == 5) ? 32'h103 : 32'h100 + 32'(c - 1);
                n_chk++;
                if (bus.ram_addr_o !== ea) begin
                    n_fail++;
                    $display("FAIL wl_addr c=%0d got %h exp %h",
                             c, bus.ram_addr_o, ea);
                end
            end
            if (c == 6) begin
                n_chk++;
                if (bus.mem_rdata_o !== 32'h44332211) begin
                    n_fail++;
                    $display("FAIL wl_rdata got %h exp 44332211",
                             bus.mem_rdata_o);
                end
            end
            next_cycle();
        end
        bus.mem_req_i = 1'b0;
    endtask

    task automatic test_half_store;
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b1;
        bus.mem_size_i = 2'd1;
        bus.mem_addr_i = 32'h201;
        bus.mem_wdata_i = 32'hDEADBEEF;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (bus.ram_wr_o !== (c == 1 || c == 2)) begin
                n_fail++;
                $display("FAIL hs_wr c=%0d got %b", c, bus.ram_wr_o);
            end
            n_chk++;
            if (bus.mem_done_o !== (c == 3) || bus.stall_o !== (c <= 2)) begin
                n_fail++;
                $display("FAIL hs_done_stall c=%0d got %b%b",
                         c, bus.mem_done_o, bus.stall_o);
            end
            if (c == 1) begin
                n_chk++;
                if (bus.ram_addr_o !== 32'h201 || bus.ram_dout_o !== 8'hEF) begin
                    n_fail++;
                    $display("FAIL hs_b0 got %h/%h exp 00000201/ef",
                             bus.ram_addr_o, bus.ram_dout_o);
                end
            end
            if (c == 2) begin
                n_chk++;
                if (bus.ram_addr_o !== 32'h202 || bus.ram_dout_o !== 8'hBE) begin
                    n_fail++;
                    $display("FAIL hs_b1 got %h/%h exp 00000202/be",
                             bus.ram_addr_o, bus.ram_dout_o);
                end
            end
            next_cycle();
        end
        bus.mem_req_i = 1'b0;
        n_chk++;
        if (ram[12'h201] !== 8'hEF || ram[12'h202] !== 8'hBE
            || ram[12'h203] !== 8'h77) begin
            n_fail++;
            $display("FAIL hs_ram got %h %h %h exp ef be 77",
                     ram[12'h201], ram[12'h202], ram[12'h203]);
        end
    endtask

    task automatic test_wrap_load;
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b0;
        bus.mem_size_i = 2'd1;
        bus.mem_addr_i = 32'hFFFF_FFFF;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_chk++;
                if (bus.ram_addr_o !== 32'hFFFF_FFFF) begin
                    n_fail++;
                    $display("FAIL wrap_a0 got %h exp ffffffff", bus.ram_addr_o);
                end
            end
            if (c == 2 || c == 3) begin
                n_chk++;
                if (bus.ram_addr_o !== 32'h0) begin
                    n_fail++;
                    $display("FAIL wrap_a1 c=%0d got %h exp 0",
                             c, bus.ram_addr_o);
                end
            end
            n_chk++;
            if (bus.mem_done_o !== (c == 4)) begin
                n_fail++;
                $display("FAIL wrap_done c=%0d got %b", c, bus.mem_done_o);
            end
            if (c == 4) begin
                n_chk++;
                if (bus.mem_rdata_o !== 32'h0000C39A) begin
                    n_fail++;
                    $display("FAIL wrap_rdata got %h exp 0000c39a",
                             bus.mem_rdata_o);
                end
            end
            next_cycle();
        end
        bus.mem_req_i = 1'b0;
    endtask

    task automatic test_back_to_back;
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b1;
        bus.mem_size_i = 2'd0;
        bus.mem_addr_i = 32'h400;
        bus.mem_wdata_i = 32'h0000005A;
        for (int c = 0; c <= 6; c++) begin
            if (c == 2) begin
                bus.mem_we_i = 1'b0;
                bus.mem_size_i = 2'd0;
            end
            @(negedge clk);
            n_chk++;
            if (bus.stall_o !== (c != 2 && c != 6)) begin
                n_fail++;
                $display("FAIL b2b_stall c=%0d got %b", c, bus.stall_o);
            end
            n_chk++;
            if (bus.mem_done_o !== (c == 2 || c == 6)) begin
                n_fail++;
                $display("FAIL b2b_done c=%0d got %b", c, bus.mem_done_o);
            end
            if (c == 6) begin
                n_chk++;
                if (bus.mem_rdata_o !== 32'h0000005A) begin
                    n_fail++;
                    $display("FAIL b2b_rdata got %h exp 0000005a",
                             bus.mem_rdata_o);
                end
            end
            next_cycle();
        end
        bus.mem_req_i = 1'b0;
    endtask

    task automatic test_rdy_low;
        logic [31:0] ea;
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b0;
        bus.mem_size_i = 2'd2;
        bus.mem_addr_i = 32'h100;
        for (int c = 0; c <= 9; c++) begin
            rdy = !(c >= 3 && c <= 5);
            @(negedge clk);
            if (c >= 1 && c <= 8) begin
                ea = (c <= 5) ? 32'h100 + 32'((c > 2) ? 1 : c - 1) :
                     (c == 6) ? 32'h102 : 32'h103;
                n_chk++;
                if (bus.ram_addr_o !== ea) begin
                    n_fail++;
                    $display("FAIL rdy_addr c=%0d got %h exp %h",
                             c, bus.ram_addr_o, ea);
                end
            end
            n_chk++;
            if (bus.ram_wr_o !== 1'b0 || bus.mem_done_o !== (c == 9)) begin
                n_fail++;
                $display("FAIL rdy_wr_done c=%0d got %b%b exp 0%b",
                         c, bus.ram_wr_o, bus.mem_done_o, (c == 9));
            end
            if (c == 9) begin
                n_chk++;
                if (bus.mem_rdata_o !== 32'h44332211) begin
                    n_fail++;
                    $display("FAIL rdy_rdata got %h exp 44332211",
                             bus.mem_rdata_o);
                end
            end
            next_cycle();
        end
        rdy = 1'b1;
        bus.mem_req_i = 1'b0;
    endtask

    task automatic test_reset_mid_store;
        bus.mem_req_i = 1'b1;
        bus.mem_we_i = 1'b1;
        bus.mem_size_i = 2'd2;
        bus.mem_addr_i = 32'h300;
        bus.mem_wdata_i = 32'h04030201;
        @(negedge clk);
        n_chk++;
        if (bus.stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rms_accept got %b exp 1", bus.stall_o);
        end
        next_cycle();
        @(negedge clk);
        n_chk++;
        if (bus.ram_wr_o !== 1'b1 || bus.ram_dout_o !== 8'h01) begin
            n_fail++;
            $display("FAIL rms_b0 got %b/%h exp 1/01",
                     bus.ram_wr_o, bus.ram_dout_o);
        end
        next_cycle();
        #1;
        rst = 1'b0;
        bus.mem_req_i = 1'b0;
        #1;
        n_chk++;
        if (bus.ram_wr_o !== 1'b0 || bus.stall_o !== 1'b0
            || bus.mem_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rms_async got wr=%b stall=%b done=%b exp 000",
                     bus.ram_wr_o, bus.stall_o, bus.mem_done_o);
        end
        n_chk++;
        if (bus.mem_rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rms_rdata got %h exp 0", bus.mem_rdata_o);
        end
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_chk++;
            if (bus.mem_done_o !== 1'b0 || bus.stall_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rms_idle c=%0d got done=%b stall=%b",
                         c, bus.mem_done_o, bus.stall_o);
            end
            next_cycle();
        end
        n_chk++;
        if (ram[12'h300] !== 8'h01 || ram[12'h301] !== 8'hFF
            || ram[12'h302] !== 8'hFF || ram[12'h303] !== 8'hFF) begin
            n_fail++;
            $display("FAIL rms_ram got %h %h %h %h exp 01 ff ff ff",
                     ram[12'h300], ram[12'h301], ram[12'h302], ram[12'h303]);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bk_we  = 1'b0;
        bk_a   = '0;
        bk_d   = '0;
        test_reset();
        poke(12'h010, 8'hAB);
        poke(12'h011, 8'h5C);
        poke(12'h100, 8'h11);
        poke(12'h101, 8'h22);
        poke(12'h102, 8'h33);
        poke(12'h103, 8'h44);
        poke(12'h203, 8'h77);
        poke(12'hFFF, 8'h9A);
        poke(12'h000, 8'hC3);
        poke(12'h400, 8'h00);
        for (int i = 0; i < 4; i++)
            poke(12'h300 + 12'(i), 8'hFF);
        test_if_fetch();
        test_word_load();
        test_half_store();
        test_wrap_load();
        test_back_to_back();
        test_rdy_low();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-bus memory controller: the responder for the instruction-fetch byte stream and the data-memory port of the MEM stage. It owns the single byte-wide RAM port (1-cycle read latency) and arbitrates between the two clients; MEM has priority over IF. It sequences multi-byte loads and stores as serial byte accesses and stalls IF while MEM owns the bus.

## Interface
Parameters:
- ADDR_W, 32, address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global ready; low freezes the controller.
- if_en_i  input  1  IF requests the byte at if_addr_i this cycle.
- if_addr_i  input  ADDR_W  IF byte address.
- if_byte_o  output  8  byte for the IF address issued in the previous cycle.
- stall_o  output  1  IF must hold its address and counters.
- mem_req_i  input  1  MEM stage access request; held until mem_done_o.
- mem_we_i  input  1  1 = store, 0 = load.
- mem_size_i  input  2  0 = byte, 1 = half, 2 = word, 3 = word.
- mem_addr_i  input  ADDR_W  start byte address; any alignment is allowed.
- mem_wdata_i  input  32  store data, little-endian, low bytes first.
- mem_rdata_o  output  32  load data, zero-extended; sign extension is done in MEM.
- mem_done_o  output  1  one-cycle completion pulse.
- ram_addr_o  output  ADDR_W  RAM byte address.
- ram_wr_o  output  1  RAM write strobe.
- ram_dout_o  output  8  RAM write byte.
- ram_din_i  input  8  RAM read byte for the address presented in the previous cycle.

## Operation
- FSM states: IDLE, READ, WRITE. Step counter cnt is 3 bits. n = 1, 2 or 4, from mem_size_i.
- **IDLE**
  - IF owns the bus: ram_addr_o = if_addr_i, ram_wr_o = 0.
  - if_byte_o = ram_din_i, passed through combinationally.
  - If mem_req_i is high and mem_done_o is low, the request is accepted. Address, write data, size and direction are latched, cnt is set to 0, and the FSM moves to READ or WRITE.
  - stall_o is high combinationally in the accept cycle.
- **WRITE**
  - Step c (0..n-1): ram_addr_o = addr+c, ram_wr_o = 1, ram_dout_o = wdata[8c+7:8c].
  - After step n-1, go to IDLE and set mem_done_o for one cycle.
- **READ**
  - Steps c = 0..n: for c < n, ram_addr_o = addr+c.
  - For c ≥ 1, capture ram_din_i into rdata[8(c-1)+7:8(c-1)].
  - At step n, hold the last address, then go to IDLE with mem_done_o set.
- mem_rdata_o: upper bytes beyond n are 0. The value holds until the next load is accepted.
- stall_o: high in READ, in WRITE and in the accept cycle; low in the done cycle. IF re-presents its frozen address in the done cycle.
- **rdy low**
  - State, cnt and rdata are frozen; ram_wr_o is forced to 0; no capture.
  - ram_addr_o is driven from a register holding the last address issued in a rdy-high cycle, so ram_din_i stays valid for the pending capture.
- **Reset (rst low)**, immediate and asynchronous:
  - state = IDLE, cnt = 0.
  - mem_done_o = 0, mem_rdata_o = 0.
  - ram_wr_o = 0, stall_o = 0.
  - A store in progress is abandoned after the bytes already written.

## Timing
- Accept edge is cycle 0.
- Store: bus cycles 1..n; mem_done_o in cycle n+1.
- Load: bus cycles 1..n+1; mem_done_o and mem_rdata_o valid in cycle n+2. Word load: done in cycle 6.
- IF byte latency: 1 cycle; no stall when MEM is idle.
- Every rdy-low cycle extends latency by one cycle.
- Back-to-back MEM requests: at least one IDLE cycle (the done cycle) between them.

## Structure
- Shared package constants: SIZE_BYTE, SIZE_HALF, SIZE_WORD, and the FSM state encoding.
- Single module; no sub-module is warranted.

## Test plan
- **IF byte fetch:** RAM[0x10] = 0xAB, if_en_i = 1, if_addr_i = 0x10, MEM idle → ram_addr_o = 0x10 in the same cycle; if_byte_o = 0xAB the next cycle; stall_o = 0.
- **Word load:** RAM[0x100..0x103] = 11,22,33,44, load of size 2 → ram_addr_o = 0x100..0x103 in cycles 1..4; mem_done_o in cycle 6 with mem_rdata_o = 0x44332211; stall_o high in cycles 0..5.
- **Half store:** addr 0x201, wdata 0xDEADBEEF → cycle 1 writes 0xEF to 0x201, cycle 2 writes 0xBE to 0x202; mem_done_o in cycle 3; RAM[0x203] unchanged.
- **Contention:** if_en_i and mem_req_i high together in IDLE → MEM accepted, stall_o high in that cycle; IF address returns on the bus in the done cycle.
- **rdy low mid-load:** rdy low for 3 cycles during step 2 of a word load → no writes, address held at the last issued address; mem_rdata_o = 0x44332211 with done delayed by 3 cycles.
- **Reset mid-store:** rst low in cycle 2 of a word store → ram_wr_o = 0 immediately; only byte 0 is written; after release, state is IDLE and no done pulse occurs.
